// File: rtl/hist_eq_pkg.sv
// Shared histogram-equalisation constants and the LUT sequencer state encoding.
// No logic; imported by the sequencer, its divider and the frame controller.
// No backpressure; constants only.
package hist_eq_pkg;

    localparam int NUM_BINS = 256;
    localparam int BIN_W    = 8;
    localparam int CDF_W    = 20;
    localparam int PIXELS   = 307200;
    localparam int OUT_MAX  = 255;
    localparam int NUM_W    = 28;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        DIVIDE,
        WRITE,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/serial_divider.sv
// Restoring N_W-bit / D_W-bit divider, one quotient bit per cycle, MSB first.
// Latency: the start edge performs the first step; done pulses N_W cycles after start.
// No backpressure: a start while running restarts the division.
module serial_divider
    import hist_eq_pkg::*;
#(
    parameter int N_W = NUM_W,
    parameter int D_W = CDF_W
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] numerator,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder
);

    localparam int CNT_W = $clog2(N_W + 1);

    logic [D_W-1:0]   rem_q, rem_n, src_rem, div_q, src_div;
    logic [N_W-1:0]   work_q, work_n, src_work;
    logic [D_W:0]     trial, diff;
    logic [CNT_W-1:0] cnt_q;
    logic             qbit;

    // work_q shifts numerator bits out of the top while quotient bits fill the bottom
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_work = start ? numerator : work_q;
        src_div  = start ? divisor : div_q;
        trial    = {src_rem, src_work[N_W-1]};
        diff     = trial - {1'b0, src_div};
        qbit     = (trial >= {1'b0, src_div});
        rem_n    = qbit ? diff[D_W-1:0] : trial[D_W-1:0];
        work_n   = {src_work[N_W-2:0], qbit};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q  <= '0;
            work_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q  <= rem_n;
                work_q <= work_n;
                div_q  <= divisor;
                cnt_q  <= CNT_W'(N_W - 1);
            end else if (cnt_q != '0) begin
                rem_q  <= rem_n;
                work_q <= work_n;
                cnt_q  <= cnt_q - 1'b1;
                done   <= (cnt_q == CNT_W'(1));
            end
        end
    end

    assign quotient  = work_q;
    assign remainder = rem_q;

endmodule

// File: rtl/cdf_lut_sequencer.sv
// Walks all CDF bins and writes (cdf-cdf_min)*255/(PIXELS-cdf_min) into one LUT bank; CDF_LUT_ROUND_EN selects round-half-up.
// Latency: 31 cycles per bin, done 7937 cycles after start (1 cycle on the cdf_min >= PIXELS error path).
// No backpressure: RAM read data is assumed one cycle after cdf_rd_en; start is ignored while not IDLE.
module cdf_lut_sequencer
    import hist_eq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             bank_sel,
    input  logic [CDF_W-1:0] cdf_min,
    output logic             busy,
    output logic             done,
    output logic             div_err,
    output logic             cdf_rd_en,
    output logic [BIN_W-1:0] cdf_rd_addr,
    input  logic [CDF_W-1:0] cdf_rd_data,
    output logic             lut_wr_en,
    output logic [BIN_W:0]   lut_wr_addr,
    output logic [7:0]       lut_wr_data
);

    localparam logic [CDF_W-1:0] PIX_C = CDF_W'(PIXELS);

    seq_state_t       state, next_state;
    logic             bank_q, err_q;
    logic [CDF_W-1:0] min_q, divisor_q, cdf_diff;
    logic [BIN_W-1:0] bin_q, bin_next;
    logic [NUM_W-1:0] num, div_quot;
    logic [7:0]       lut_val;
    logic             div_done;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        bin_next   = bin_q;
        case (state)
            IDLE: if (start) begin
                next_state = (cdf_min >= PIX_C) ? FINISH : READ;
                bin_next   = '0;
            end
            READ:   next_state = WAIT;
            WAIT:   next_state = DIVIDE;
            DIVIDE: if (div_done) next_state = WRITE;
            WRITE: begin
                if (bin_q == BIN_W'(NUM_BINS - 1)) begin
                    next_state = FINISH;
                end else begin
                    next_state = READ;
                    bin_next   = bin_q + 1'b1;
                end
            end
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bins below cdf_min map to zero rather than wrapping
    always_comb begin
        cdf_diff = (cdf_rd_data > min_q) ? (cdf_rd_data - min_q) : '0;
        num      = NUM_W'(cdf_diff) * NUM_W'(OUT_MAX);
`ifdef CDF_LUT_ROUND_EN
        num      = num + NUM_W'(divisor_q >> 1);
`endif
        lut_val  = (div_quot > NUM_W'(OUT_MAX)) ? 8'(OUT_MAX) : div_quot[7:0];
    end

    serial_divider #(.N_W(NUM_W), .D_W(CDF_W)) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (state == WAIT),
        .numerator (num),
        .divisor   (divisor_q),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder ()
    );

    // Strobes track next_state so they coincide with their state; done/div_err trail FINISH by a cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            bank_q      <= 1'b0;
            err_q       <= 1'b0;
            min_q       <= '0;
            divisor_q   <= '0;
            bin_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_err     <= 1'b0;
            cdf_rd_en   <= 1'b0;
            cdf_rd_addr <= '0;
            lut_wr_en   <= 1'b0;
            lut_wr_addr <= '0;
            lut_wr_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                bank_q    <= bank_sel;
                min_q     <= cdf_min;
                divisor_q <= PIX_C - cdf_min;
                err_q     <= (cdf_min >= PIX_C);
            end
            bin_q     <= bin_next;
            busy      <= next_state inside {READ, WAIT, DIVIDE, WRITE};
            cdf_rd_en <= (next_state == READ);
            if (next_state == READ) cdf_rd_addr <= bin_next;
            lut_wr_en <= (next_state == WRITE);
            if (next_state == WRITE) begin
                lut_wr_addr <= {bank_q, bin_q};
                lut_wr_data <= lut_val;
            end
            done    <= (state == FINISH);
            div_err <= (state == FINISH) && err_q;
        end
    end

endmodule

// File: tb/tb_cdf_lut_sequencer.sv
// Directed bench for cdf_lut_sequencer: CDF RAM model, LUT write monitor, table of expected LUT values.
module tb_cdf_lut_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        bank_sel = 1'b0;
    logic [19:0] cdf_min = '0;
    logic        busy, done, div_err, cdf_rd_en, lut_wr_en;
    logic [7:0]  cdf_rd_addr, lut_wr_data;
    logic [19:0] cdf_rd_data = '0;
    logic [8:0]  lut_wr_addr;

    logic [19:0] cdf_mem [256];
    int          lut_mem [512];
    int          wr_q [$];
    int          done_cnt, err_cnt;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        int run;
        int addr;
        int exp_t;
        int exp_r;
    } vec_t;
    vec_t vt [15];

    cdf_lut_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bank_sel    (bank_sel),
        .cdf_min     (cdf_min),
        .busy        (busy),
        .done        (done),
        .div_err     (div_err),
        .cdf_rd_en   (cdf_rd_en),
        .cdf_rd_addr (cdf_rd_addr),
        .cdf_rd_data (cdf_rd_data),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (cdf_rd_en) cdf_rd_data <= cdf_mem[cdf_rd_addr];

    always @(negedge clock) begin
        if (lut_wr_en) begin
            lut_mem[lut_wr_addr] = int'(lut_wr_data);
            wr_q.push_back(int'(lut_wr_addr));
        end
        if (done) done_cnt++;
        if (div_err) err_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = 0; i < 512; i++) lut_mem[i] = -1;
    endtask

    task automatic run_build(input logic bk, input logic [19:0] cm, input bit mid_start,
                             output int cycles);
        clear_log();
        @(negedge clock);
        start = 1'b1; bank_sel = bk; cdf_min = cm;
        @(posedge clock); #1;
        start = 1'b0;
        cycles = 0;
        while (cycles < 9000) begin
            @(posedge clock); cycles++; #1;
            if (mid_start) begin
                start = (cycles == 500);
                if (cycles == 5) chk("busy_mid_run", int'(busy), 1);
            end
            if (done) break;
        end
        chk("done_seen", int'(done), 1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_table(input int run);
        for (int i = 0; i < 15; i++) begin
            if (vt[i].run == run) begin
`ifdef CDF_LUT_ROUND_EN
                chk($sformatf("lut[%0d]", vt[i].addr), lut_mem[vt[i].addr], vt[i].exp_r);
`else
                chk($sformatf("lut[%0d]", vt[i].addr), lut_mem[vt[i].addr], vt[i].exp_t);
`endif
            end
        end
    endtask

    task automatic check_order(input int base);
        int bad;
        bad = 0;
        chk("write_count", wr_q.size(), 256);
        for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] != base + i) bad++;
        chk("write_order", bad, 0);
    endtask

    initial begin
        int cyc;
        int bad;

        vt[0]  = '{0, 0,   0,   1};
        vt[1]  = '{0, 1,   1,   2};
        vt[2]  = '{0, 63,  63,  64};
        vt[3]  = '{0, 127, 127, 128};
        vt[4]  = '{0, 200, 200, 200};
        vt[5]  = '{0, 255, 255, 255};
        vt[6]  = '{1, 256, 0,   0};
        vt[7]  = '{1, 265, 0,   0};
        vt[8]  = '{1, 266, 0,   0};
        vt[9]  = '{1, 276, 10,  10};
        vt[10] = '{1, 391, 126, 127};
        vt[11] = '{1, 511, 255, 255};
        vt[12] = '{2, 10,  255, 255};
        vt[13] = '{2, 11,  11,  12};
        vt[14] = '{2, 255, 255, 255};

        for (int i = 0; i < 256; i++) cdf_mem[i] = 20'(1200 * (i + 1));

        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_div_err", int'(div_err), 0);
        chk("rst_cdf_rd_en", int'(cdf_rd_en), 0);
        chk("rst_cdf_rd_addr", int'(cdf_rd_addr), 0);
        chk("rst_lut_wr_en", int'(lut_wr_en), 0);
        chk("rst_lut_wr_addr", int'(lut_wr_addr), 0);
        chk("rst_lut_wr_data", int'(lut_wr_data), 0);
        @(negedge clock);
        reset = 1'b0;

        // Linear CDF into bank 0 with a stray start at cycle 500
        run_build(1'b0, 20'd0, 1'b1, cyc);
        chk("lin_cycles", cyc, 7937);
        chk("lin_done_cnt", done_cnt, 1);
        chk("lin_err_cnt", err_cnt, 0);
        check_order(0);
        check_table(0);

        // Divisor zero and negative: error pulse, no writes
        run_build(1'b0, 20'd307200, 1'b0, cyc);
        chk("err0_cycles", cyc, 1);
        chk("err0_err_cnt", err_cnt, 1);
        chk("err0_done_cnt", done_cnt, 1);
        chk("err0_writes", wr_q.size(), 0);
        run_build(1'b1, 20'd400000, 1'b0, cyc);
        chk("err1_cycles", cyc, 1);
        chk("err1_err_cnt", err_cnt, 1);
        chk("err1_writes", wr_q.size(), 0);

        // cdf_min=5000 into bank 1; first ten bins fall below cdf_min
        for (int i = 0; i < 10; i++) cdf_mem[i] = 20'(400 * (i + 1));
        for (int i = 10; i < 255; i++) cdf_mem[i] = 20'(5000 + 1200 * (i - 10));
        cdf_mem[255] = 20'd307200;
        run_build(1'b1, 20'd5000, 1'b0, cyc);
        chk("min_cycles", cyc, 7937);
        chk("min_err_cnt", err_cnt, 0);
        check_order(256);
        check_table(1);
        bad = 0;
        for (int i = 257; i < 512; i++) if (lut_mem[i] < lut_mem[i-1]) bad++;
        chk("min_monotonic", bad, 0);

        // Reset during bin 100's DIVIDE phase
        for (int i = 0; i < 256; i++) cdf_mem[i] = 20'(1200 * (i + 1));
        clear_log();
        @(negedge clock);
        start = 1'b1; bank_sel = 1'b0; cdf_min = 20'd0;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 3110) begin
            @(posedge clock); cyc++;
        end
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_writes", wr_q.size(), 100);
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        chk("abort_writes_after", wr_q.size(), 100);
        chk("abort_done_cnt", done_cnt, 0);

        // Restart after abort; bin 10 overshoots PIXELS to exercise the clamp
        cdf_mem[10] = 20'd600000;
        run_build(1'b0, 20'd0, 1'b0, cyc);
        chk("restart_cycles", cyc, 7937);
        chk("restart_done_cnt", done_cnt, 1);
        check_order(0);
        check_table(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
